bpsk_modulator: RTL

Transmit-side BPSK modulator: accepts a bit stream over a valid/ready handshake and produces one signed carrier sample per clock. Each bit occupies exactly one symbol period of WAVELENGTH clocks; bit 0 is sent as the in-phase carrier and bit 1 as the inverted carrier. The output feeds the sample path that the BPSK demodulator consumes, and it shares that block's phase convention and symbol period.

---
 rtl/bpsk_pkg.sv | 15 +
 rtl/bpsk_modulator_sine_wave.sv | 41 ++++
 rtl/bpsk_modulator.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: default sample width, symbol period and the state
// encoding used by both the modulator and the demodulator.
package bpsk_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned WAVELENGTH = 16;
  localparam int unsigned PHASE_W    = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } bpsk_state_e;

endpackage

// File: rtl/bpsk_modulator_sine_wave.sv
// One-period carrier lookup: amp = sine of phase over WAVELENGTH steps, full
// scale (+max on the positive half, -2^(W-1) on the negative half).
module sine_wave #(
  parameter int unsigned DATA_WIDTH = bpsk_pkg::DATA_WIDTH,
  parameter int unsigned WAVELENGTH = bpsk_pkg::WAVELENGTH
) (
  input  logic [bpsk_pkg::PHASE_W-1:0] phase,
  output logic signed [DATA_WIDTH-1:0] amp
);
  import bpsk_pkg::*;

  localparam int unsigned IW     = (WAVELENGTH > 1) ? $clog2(WAVELENGTH) : 1;
  localparam longint      POS_PK = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;
  localparam longint      NEG_PK = longint'(1) <<< (DATA_WIDTH - 1);

  // Integer rational sine approximation, exact at 0, peaks and zero crossings
  function automatic longint sine_calc(input longint p);
    longint w;
    longint q2;
    longint a;
    longint den;
    w   = longint'(WAVELENGTH);
    q2  = (2 * p < w) ? 2 * p : 2 * p - w;
    a   = q2 * (w - q2);
    den = 5 * w * w - 4 * a;
    if (2 * p < w) return (POS_PK * 16 * a) / den;
    return -((NEG_PK * 16 * a) / den);
  endfunction

  logic signed [DATA_WIDTH-1:0] rom [WAVELENGTH];

  for (genvar i = 0; i < int'(WAVELENGTH); i++) begin : g_rom
    assign rom[i] = DATA_WIDTH'(sine_calc(longint'(i)));
  end

  always_comb begin
    amp = '0;
    if (phase < PHASE_W'(WAVELENGTH)) amp = rom[phase[IW-1:0]];
  end

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK transmitter: bit handshake into a 1-entry buffer, one carrier sample per
// clock, bit 1 inverts the carrier. Optional preamble via BPSK_PREAMBLE_EN.
module bpsk_modulator #(
  parameter int unsigned DATA_WIDTH   = bpsk_pkg::DATA_WIDTH,
  parameter int unsigned WAVELENGTH   = bpsk_pkg::WAVELENGTH,
  parameter int unsigned PREAMBLE_LEN = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic signed [DATA_WIDTH-1:0] sample,
  output logic                         sample_valid,
  output logic                         symbol_start,
  output logic                         busy
);
  import bpsk_pkg::*;

  localparam int unsigned PW = PHASE_W;
  localparam logic [PW-1:0] LAST_PHASE = PW'(WAVELENGTH - 1);
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  if (WAVELENGTH < 4 || PREAMBLE_LEN < 1) begin : g_param_check
    $error("bpsk_modulator: WAVELENGTH must be >= 4 and PREAMBLE_LEN >= 1");
  end

  // Negation that maps the most negative code to the most positive one
  function automatic logic signed [DATA_WIDTH-1:0] neg_sat(
    input logic signed [DATA_WIDTH-1:0] x
  );
    if (x == S_MIN) return S_MAX;
    return -x;
  endfunction

  bpsk_state_e                  state_q, state_d;
  logic [PW-1:0]                phase_q, phase_d;
  logic                         buf_bit_q, buf_bit_d;
  logic                         buf_full_q, buf_full_d;
  logic                         cur_bit_q, cur_bit_d;
  logic signed [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                         sample_valid_q, sample_valid_d;
  logic                         symbol_start_q, symbol_start_d;
  logic signed [DATA_WIDTH-1:0] amp;
  logic                         last_phase;
`ifdef BPSK_PREAMBLE_EN
  localparam logic [PW-1:0] LAST_SYM = PW'(PREAMBLE_LEN - 1);
  logic [PW-1:0]                sym_cnt_q, sym_cnt_d;
`endif

  sine_wave #(
    .DATA_WIDTH (DATA_WIDTH),
    .WAVELENGTH (WAVELENGTH)
  ) u_sine (
    .phase (phase_q),
    .amp   (amp)
  );

  assign last_phase   = (phase_q == LAST_PHASE);
  assign bit_ready    = !buf_full_q;
  assign busy         = (state_q != IDLE);
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign symbol_start = symbol_start_q;

  // Next-state, buffer and sample computation
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    buf_bit_d      = buf_bit_q;
    buf_full_d     = buf_full_q;
    cur_bit_d      = cur_bit_q;
    sample_d       = '0;
    sample_valid_d = 1'b0;
    symbol_start_d = 1'b0;
`ifdef BPSK_PREAMBLE_EN
    sym_cnt_d      = sym_cnt_q;
`endif

    if (bit_valid && !buf_full_q) begin
      buf_bit_d  = bit_in;
      buf_full_d = 1'b1;
    end

    if (state_q != IDLE) begin
      sample_d       = cur_bit_q ? neg_sat(amp) : amp;
      sample_valid_d = 1'b1;
      symbol_start_d = (phase_q == '0);
      phase_d        = last_phase ? '0 : phase_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          phase_d = '0;
`ifdef BPSK_PREAMBLE_EN
          state_d   = PREAMBLE;
          sym_cnt_d = '0;
          cur_bit_d = 1'b0;
`else
          state_d    = DATA;
          cur_bit_d  = buf_bit_q;
          buf_full_d = 1'b0;
`endif
        end
      end
`ifdef BPSK_PREAMBLE_EN
      PREAMBLE: begin
        if (last_phase) begin
          if (sym_cnt_q == LAST_SYM) begin
            state_d    = DATA;
            cur_bit_d  = buf_bit_q;
            buf_full_d = 1'b0;
          end else begin
            sym_cnt_d = sym_cnt_q + PW'(1);
            cur_bit_d = !cur_bit_q;
          end
        end
      end
`endif
      DATA: begin
        if (last_phase) begin
          if (buf_full_q) begin
            cur_bit_d  = buf_bit_q;
            buf_full_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      buf_bit_q      <= 1'b0;
      buf_full_q     <= 1'b0;
      cur_bit_q      <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      symbol_start_q <= 1'b0;
`ifdef BPSK_PREAMBLE_EN
      sym_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      buf_bit_q      <= buf_bit_d;
      buf_full_q     <= buf_full_d;
      cur_bit_q      <= cur_bit_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      symbol_start_q <= symbol_start_d;
`ifdef BPSK_PREAMBLE_EN
      sym_cnt_q      <= sym_cnt_d;
`endif
    end
  end

endmodule
